div_iter: RTL and testbench
===========================

DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Port list (name, direction, width, meaning):
- clk, in, 1: pipeline clock.
- resetn, in, 1: async active-low reset.
- start, in, 1: DIV/DIVU occupies E stage; held high while the instruction sits in E.
- signed_div, in, 1: 1 = DIV (signed), 0 = DIVU.
- a, in, 32: dividend (rs, E stage).
- b, in, 32: divisor (rt, E stage).
- hold, in, 1: E frozen by another source (i/d cache stall).
- cancel, in, 1: exception flush at M (flush_exceptionM).
- stall, out, 1: divider contribution to alu_stallE.
- done, out, 1: quotient/remainder valid.
- quot, out, 32: quotient, to HI/LO write path (LO).
- rem, out, 32: remainder (HI).

Function
REQ-003 The FSM SHALL have exactly three states, IDLE, BUSY and DONE, plus a 5-bit iteration counter.
REQ-004 In IDLE with start=1 and cancel=0, the block SHALL latch |a|, |b|, the sign of a and the sign of a XOR the sign of b (magnitudes only when signed_div=1), clear the counter and go to BUSY.
REQ-005 In BUSY, each cycle SHALL perform one restoring shift-subtract step, producing one quotient bit MSB-first.
REQ-006 BUSY SHALL transition to DONE after the step with counter=31, giving exactly 32 BUSY cycles.
REQ-007 stall SHALL equal (IDLE & start & ~cancel) | BUSY, evaluated combinationally.
- stall is high for 33 cycles: the start cycle plus 32 BUSY cycles.
- stall is low in DONE.
REQ-008 done SHALL be 1 only in DONE.
REQ-009 quot and rem SHALL be registered and SHALL hold their last value outside DONE.
REQ-010 In DONE with hold=1, the block SHALL stay in DONE with outputs stable; start remaining high SHALL NOT restart a division.
REQ-011 In DONE with hold=0, the block SHALL return to IDLE on the next edge (the instruction leaves E).
- A start seen in the following IDLE cycle is a new division.
REQ-012 Sign correction SHALL be applied when entering DONE:
- quot is negated if the latched sign XOR is 1.
- rem is negated if the dividend was negative.
- Correction applies only when signed_div=1.
REQ-013 Divide by zero SHALL give quot=32'hFFFFFFFF and rem=a in both modes.
REQ-014 Signed 32'h80000000 / 32'hFFFFFFFF SHALL give quot=32'h80000000, rem=0.
REQ-015 cancel=1 SHALL force stall=0 in the same cycle and SHALL move any state to IDLE on the next edge, discarding work; quot/rem remain unchanged.
REQ-016 cancel has priority over start and hold.
REQ-017 Operand changes on a/b after the start cycle SHALL NOT affect the result.

Reset
REQ-018 While resetn=0, the block SHALL hold:
- state=IDLE, counter=0;
- quot=0, rem=0, done=0;
- all internal operand and sign registers cleared.
REQ-019 stall SHALL be 0 during reset regardless of start.
REQ-020 Deassertion of resetn mid-division SHALL leave the block in IDLE with no stale done.

Configuration
REQ-021 Macro DIV_FAST_PATH_EN SHALL gate the fast path.
- Defined: in IDLE with start, if b==0 or |a|<|b| (unsigned magnitude compare), the block SHALL go directly to DONE with quot=0/rem=a (or per REQ-013 for b==0, sign-corrected per REQ-012); stall is high for the start cycle only.
- Undefined: every division, including these cases, takes the full 32 BUSY cycles; results are identical either way.

Verification
REQ-022 DIVU a=100, b=7, hold=0 -> stall high 33 cycles, then done=1 with quot=14, rem=2; IDLE next cycle.
REQ-023 DIV a=-7 (32'hFFFFFFF9), b=2 -> quot=32'hFFFFFFFD (-3), rem=32'hFFFFFFFF (-1).
REQ-024 DIV a=32'h80000000, b=32'hFFFFFFFF -> quot=32'h80000000, rem=0.
REQ-025 DIVU a=5, b=0 -> quot=32'hFFFFFFFF, rem=5.
- With DIV_FAST_PATH_EN: stall high 1 cycle.
- Without: stall high 33 cycles.
REQ-026 DIVU 100/7 with cancel pulsed at BUSY cycle 10 -> stall=0 that cycle, IDLE next edge, done never asserted, quot/rem unchanged; a new start afterwards computes correctly.
REQ-027 Completion with hold=1 for 5 cycles and start held high -> done=1 and results stable all 5 cycles, no restart; IDLE one cycle after hold drops.

Source files
------------

// File: rtl/div_iter.sv
// Iterative 32-bit restoring divider (DIV/DIVU) for the E stage: one quotient bit per cycle.
// Optional macro DIV_FAST_PATH_EN: b==0 or |a|<|b| finishes straight from IDLE.
module div_iter (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hold,
  input  logic        cancel,
  output logic        stall,
  output logic        done,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  qr_q, qr_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic          neg_a_q, neg_a_d;
  logic          neg_q_q, neg_q_d;
  logic          bz_q, bz_d;
  logic [W-1:0]  quot_q, quot_d;
  logic [W-1:0]  rem_q, rem_d;

  logic [W-1:0]  abs_a, abs_b;
  logic [W:0]    trial, diff;
  logic          ge;
  logic [W-1:0]  acc_nx, qr_nx;

  // Operand magnitudes and one restoring shift-subtract step
  always_comb begin
    abs_a  = (signed_div && a[W-1]) ? (~a + W'(1)) : a;
    abs_b  = (signed_div && b[W-1]) ? (~b + W'(1)) : b;
    trial  = {acc_q, qr_q[W-1]};
    diff   = trial - {1'b0, dvs_q};
    ge     = ~diff[W];
    acc_nx = ge ? diff[W-1:0] : trial[W-1:0];
    qr_nx  = {qr_q[W-2:0], ge};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    qr_d    = qr_q;
    dvs_d   = dvs_q;
    neg_a_d = neg_a_q;
    neg_q_d = neg_q_q;
    bz_d    = bz_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          qr_d    = abs_a;
          dvs_d   = abs_b;
          neg_a_d = signed_div & a[W-1];
          neg_q_d = signed_div & (a[W-1] ^ b[W-1]);
          bz_d    = (b == '0);
          cnt_d   = '0;
          state_d = S_BUSY;
`ifdef DIV_FAST_PATH_EN
          // Trivial quotient: the sign-corrected remainder is a itself
          if ((b == '0) || (abs_a < abs_b)) begin
            state_d = S_DONE;
            quot_d  = (b == '0) ? '1 : '0;
            rem_d   = a;
          end
`endif
        end
      end
      S_BUSY: begin
        acc_d = acc_nx;
        qr_d  = qr_nx;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          state_d = S_DONE;
          // Divide-by-zero keeps the all-ones quotient in both modes
          quot_d  = (neg_q_q && !bz_q) ? (~qr_nx + W'(1)) : qr_nx;
          rem_d   = neg_a_q ? (~acc_nx + W'(1)) : acc_nx;
        end
      end
      S_DONE: begin
        if (!hold) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Flush wins over everything and leaves the published results alone
    if (cancel) begin
      state_d = S_IDLE;
      quot_d  = quot_q;
      rem_d   = rem_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      qr_q    <= '0;
      dvs_q   <= '0;
      neg_a_q <= 1'b0;
      neg_q_q <= 1'b0;
      bz_q    <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      qr_q    <= qr_d;
      dvs_q   <= dvs_d;
      neg_a_q <= neg_a_d;
      neg_q_q <= neg_q_d;
      bz_q    <= bz_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
    end
  end

  assign stall = resetn & ~cancel & (((state_q == S_IDLE) & start) | (state_q == S_BUSY));
  assign done  = (state_q == S_DONE);
  assign quot  = quot_q;
  assign rem   = rem_q;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: vector table through a result scoreboard plus
// hand-written cancel, hold and mid-division reset sequences.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        signed_div;
  logic [31:0] a;
  logic [31:0] b;
  logic        hold;
  logic        cancel;
  logic        stall;
  logic        done;
  logic [31:0] quot;
  logic [31:0] rem;

  div_iter dut (
    .clk(clk), .resetn(resetn), .start(start), .signed_div(signed_div),
    .a(a), .b(b), .hold(hold), .cancel(cancel),
    .stall(stall), .done(done), .quot(quot), .rem(rem)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eq;
    logic [31:0] er;
    bit          fast;
  } vec_t;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
  } res_t;

  res_t        sb[$];
  vec_t        vecs[12];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_q   = '0;
  logic [31:0] last_r   = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic int exp_stall(input bit fast);
`ifdef DIV_FAST_PATH_EN
    return fast ? 1 : 33;
`else
    return 33;
`endif
  endfunction

  // Start a division, scramble operands while it runs, score the result and leave E
  task automatic run_vec(input vec_t v, input string tag);
    int   stalls;
    bit   seen;
    res_t exp_r;
    @(negedge clk);
    signed_div = v.sd; a = v.a; b = v.b; start = 1'b1;
    sb.push_back('{q: v.eq, r: v.er});
    #1;
    stalls = stall ? 1 : 0;
    seen   = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      a = $urandom; b = $urandom;
      #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (stall) stalls++;
    end
    check({tag, " done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      if (sb.size() == 0) begin
        check({tag, " sb_nonempty"}, 32'd0, 32'd1);
      end else begin
        exp_r = sb.pop_front();
        check({tag, " quot"}, quot, exp_r.q);
        check({tag, " rem"}, rem, exp_r.r);
        last_q = exp_r.q;
        last_r = exp_r.r;
      end
      check({tag, " stall_cycles"}, 32'(stalls), 32'(exp_stall(v.fast)));
      check({tag, " stall_in_done"}, 32'(stall), 32'd0);
    end
    start = 1'b0;
    @(negedge clk);
    #1;
    check({tag, " done_after"}, 32'(done), 32'd0);
  endtask

  initial begin
    int   busy;
    bit   bad_done;
    res_t exp_r;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
    vecs[2]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'h0,          1'b0};
    vecs[3]  = '{1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1};
    vecs[4]  = '{1'b1, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFFB,   1'b1};
    vecs[5]  = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3,          1'b1};
    vecs[6]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0};
    vecs[7]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
    vecs[8]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0};
    vecs[9]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b1};
    vecs[10] = '{1'b1, 32'hFFFFFFFD,   32'd10,         32'd0,          32'hFFFFFFFD,   1'b1};
    vecs[11] = '{1'b0, 32'h12345678,   32'd1000,       32'h0004A90B,   32'h00000380,   1'b0};

    // Reset with start asserted
    resetn = 1'b0; start = 1'b1; signed_div = 1'b0; a = 32'd100; b = 32'd7;
    hold = 1'b0; cancel = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst stall", 32'(stall), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst quot", quot, 32'd0);
    check("rst rem", rem, 32'd0);
    start = 1'b0;
    resetn = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Cancel at BUSY cycle 10
    @(negedge clk);
    signed_div = 1'b0; a = 32'd100; b = 32'd7; start = 1'b1;
    busy = 0;
    bad_done = 1'b0;
    while (busy < 10) begin
      @(negedge clk);
      busy++;
      if (done) bad_done = 1'b1;
    end
    cancel = 1'b1;
    #1;
    check("cancel stall", 32'(stall), 32'd0);
    @(negedge clk);
    cancel = 1'b0; start = 1'b0;
    #1;
    check("cancel idle_stall", 32'(stall), 32'd0);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (done) bad_done = 1'b1;
    end
    check("cancel no_done", 32'(bad_done), 32'd0);
    check("cancel quot_kept", quot, last_q);
    check("cancel rem_kept", rem, last_r);
    run_vec(vecs[0], "after_cancel");

    // Completion under hold with start still high
    @(negedge clk);
    signed_div = 1'b0; a = 32'd100; b = 32'd7; start = 1'b1;
    sb.push_back('{q: 32'd14, r: 32'd2});
    bad_done = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      #1;
      if (done) begin
        bad_done = 1'b0;
        break;
      end
    end
    check("hold done_seen", 32'(!bad_done), 32'd1);
    hold = 1'b1;
    exp_r = (sb.size() != 0) ? sb.pop_front() : '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("hold%0d done", c), 32'(done), 32'd1);
      check($sformatf("hold%0d quot", c), quot, exp_r.q);
      check($sformatf("hold%0d rem", c), rem, exp_r.r);
      check($sformatf("hold%0d stall", c), 32'(stall), 32'd0);
    end
    hold = 1'b0; start = 1'b0;
    @(negedge clk);
    #1;
    check("hold released done", 32'(done), 32'd0);

    // Reset in the middle of a division
    @(negedge clk);
    signed_div = 1'b1; a = 32'hFFFFFFF9; b = 32'd2; start = 1'b1;
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("midrst stall", 32'(stall), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst quot", quot, 32'd0);
    check("midrst rem", rem, 32'd0);
    @(negedge clk);
    start = 1'b0;
    resetn = 1'b1;
    bad_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (done || stall) bad_done = 1'b1;
    end
    check("midrst idle", 32'(bad_done), 32'd0);
    run_vec(vecs[6], "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
